// File: rtl/pattern_match_counter.sv
// Programmable serial pattern detector with a BCD match counter and per-digit
// active-low 7-segment drive. Pattern, length and overlap mode load at run time.
module pattern_match_counter #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        NUM_DIGITS  = 2,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'h05),
  parameter int unsigned        DEF_LEN     = 4,
  parameter bit                 SATURATE    = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           sig_to_test,
  input  logic                           clr_count,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  output logic                           z,
  output logic [4*NUM_DIGITS-1:0]        match_count,
  output logic                           overflow,
  output logic [8*NUM_DIGITS-1:0]        disp
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = 4 * NUM_DIGITS;
  localparam int unsigned DW = 8 * NUM_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ARMED = 3'b010,
    S_MATCH = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               z_q, z_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [DW-1:0]      disp_q, disp_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] shifted;
  logic [LW-1:0]      fill_inc;
  logic               hit;
  logic [CW-1:0]      cnt_inc;
  logic               carry;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Low len bits of the history take part in the compare.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
  end

  // Detector next state: history, fill, config and FSM.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    state_d  = state_q;
    shifted  = {hist_q[MAX_LEN-2:0], sig_to_test};
    fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);
    hit      = (fill_inc >= len_q) && ((shifted & mask) == (pat_q & mask));
    if (cfg_we) begin
      pat_d   = cfg_pattern;
      len_d   = ((cfg_len == '0) || (32'(cfg_len) > MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
      ovl_d   = cfg_overlap;
      fill_d  = '0;
      state_d = S_IDLE;
    end else if (ena) begin
      hist_d = shifted;
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
      if (hit) begin
        state_d = S_MATCH;
      end else begin
        state_d = (fill_d >= len_q) ? S_ARMED : S_IDLE;
      end
    end else begin
      state_d = (fill_q >= len_q) ? S_ARMED : S_IDLE;
    end
    z_d = (state_d == S_MATCH);
  end

  // BCD increment with per-digit carry; final carry means all-9s.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_count) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (z_q) begin
      if (carry) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : cnt_inc;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_comb begin
    disp_d = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      disp_d[8*i +: 8] = clr_count ? 8'hC0 : seg7(cnt_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= LW'(DEF_LEN);
      ovl_q   <= 1'b1;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= {NUM_DIGITS{8'hC0}};
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;
  assign disp        = disp_q;

endmodule

// File: tb/tb_pattern_match_counter.sv
// Randomized scoreboard bench for pattern_match_counter: wrapping and
// saturating instances share stimulus and are checked against a queue model.
module tb_pattern_match_counter;

  localparam int unsigned MAX_LEN = 8;
  localparam int          MAXC    = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ena, sig, clr, cfg_we, cfg_ovl;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       z_w, z_s, ovf_w, ovf_s;
  logic [7:0] cnt_w, cnt_s;
  logic [15:0] disp_w, disp_s;

  pattern_match_counter #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig), .clr_count(clr),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_ovl),
    .z(z_w), .match_count(cnt_w), .overflow(ovf_w), .disp(disp_w));

  pattern_match_counter #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .ena(ena), .sig_to_test(sig), .clr_count(clr),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_ovl),
    .z(z_s), .match_count(cnt_s), .overflow(ovf_s), .disp(disp_s));

  typedef struct {
    logic z;
    int   cw; logic ow; int dw;
    int   cs; logic os; int ds;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  // Reference model: samples since the last fill reset, newest at the back.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_z, m_ow, m_os;
  int         m_cw, m_cs, m_dw, m_ds;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd_of(input int v);
    int div = 1;
    logic [7:0] r = '0;
    for (int d = 0; d < 2; d++) begin
      r[4*d +: 4] = 4'((v / div) % 10);
      div *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] seg_of(input int v);
    logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int div = 1;
    logic [15:0] r = '0;
    for (int d = 0; d < 2; d++) begin
      r[8*d +: 8] = codes[(v / div) % 10];
      div *= 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pat = 8'h05; m_len = 4; m_ovl = 1'b1; m_z = 1'b0;
    m_cw = 0; m_cs = 0; m_ow = 1'b0; m_os = 1'b0; m_dw = 0; m_ds = 0;
  endtask

  // Advances the model across one rising edge using the applied inputs.
  task automatic model_edge();
    bit   hit;
    exp_t x;
    m_dw = clr ? 0 : m_cw;
    m_ds = clr ? 0 : m_cs;
    if (clr) begin
      m_cw = 0; m_cs = 0; m_ow = 1'b0; m_os = 1'b0;
    end else if (m_z) begin
      if (m_cw == MAXC - 1) begin m_cw = 0; m_ow = 1'b1; end
      else m_cw++;
      if (m_cs == MAXC - 1) m_os = 1'b1;
      else m_cs++;
    end
    if (cfg_we) begin
      m_pat = cfg_pat;
      m_len = (cfg_len == 4'd0 || int'(cfg_len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(cfg_len);
      m_ovl = cfg_ovl;
      mq.delete();
      m_z = 1'b0;
    end else if (ena) begin
      mq.push_back(sig);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      hit = (mq.size() >= m_len);
      for (int j = 0; j < m_len; j++) begin
        if (hit && mq[mq.size() - 1 - j] != m_pat[j]) hit = 1'b0;
      end
      m_z = hit;
      if (hit && !m_ovl) mq.delete();
    end else begin
      m_z = 1'b0;
    end
    x.z = m_z; x.cw = m_cw; x.ow = m_ow; x.dw = m_dw;
    x.cs = m_cs; x.os = m_os; x.ds = m_ds;
    exp_q.push_back(x);
  endtask

  task automatic step(input bit e_i, input bit s_i, input bit c_i = 1'b0, input bit w_i = 1'b0);
    ena = e_i; sig = s_i; clr = c_i; cfg_we = w_i;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic stream(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input bit e_i);
    cfg_pat = p; cfg_len = l; cfg_ovl = o;
    step(e_i, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_z_w"}, 32'(z_w), 32'd0);
    chk({tag, "_z_s"}, 32'(z_s), 32'd0);
    chk({tag, "_cnt_w"}, 32'(cnt_w), 32'd0);
    chk({tag, "_cnt_s"}, 32'(cnt_s), 32'd0);
    chk({tag, "_ovf_w"}, 32'(ovf_w), 32'd0);
    chk({tag, "_ovf_s"}, 32'(ovf_s), 32'd0);
    chk({tag, "_disp_w"}, 32'(disp_w), 32'hC0C0);
    chk({tag, "_disp_s"}, 32'(disp_s), 32'hC0C0);
  endtask

  // Monitor: compares every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("z_w", 32'(z_w), 32'(e.z));
      chk("z_s", 32'(z_s), 32'(e.z));
      chk("count_w", 32'(cnt_w), 32'(bcd_of(e.cw)));
      chk("count_s", 32'(cnt_s), 32'(bcd_of(e.cs)));
      chk("overflow_w", 32'(ovf_w), 32'(e.ow));
      chk("overflow_s", 32'(ovf_s), 32'(e.os));
      chk("disp_w", 32'(disp_w), 32'(seg_of(e.dw)));
      chk("disp_s", 32'(disp_s), 32'(seg_of(e.ds)));
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; sig = 1'b0; clr = 1'b0; cfg_we = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    model_reset();
    #3;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Default pattern 0101, overlapping.
    stream(8'b0001_0101, 6);
    repeat (3) step(1'b0, 1'b0);

    // Non-overlapping, loaded while a sample is offered.
    load_cfg(8'h05, 4'd4, 1'b0, 1'b1);
    stream(8'b0001_0101, 6);
    repeat (2) step(1'b0, 1'b0);

    // Gap in ena between the halves of a match.
    load_cfg(8'h05, 4'd4, 1'b0, 1'b0);
    stream(8'b0000_0001, 2);
    repeat (5) step(1'b0, 1'b1);
    stream(8'b0000_0001, 2);
    step(1'b0, 1'b0);

    // Clear together with a match pulse.
    stream(8'b0000_0101, 4);
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);

    // Out-of-range lengths load as MAX_LEN.
    load_cfg(8'hA5, 4'd0, 1'b1, 1'b0);
    stream(8'hA5, 8);
    load_cfg(8'h3C, 4'd12, 1'b0, 1'b0);
    stream(8'h3C, 8);
    step(1'b0, 1'b0);

    // 100 matches: wrap vs saturate, then clear.
    step(1'b0, 1'b0, 1'b1);
    load_cfg(8'h01, 4'd1, 1'b1, 1'b0);
    repeat (100) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);

    // Random traffic, biased toward short patterns.
    repeat (1500) begin
      bit w;
      w = ($urandom % 100) < 3;
      if (w) begin
        cfg_pat = 8'($urandom);
        cfg_len = ($urandom % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
        cfg_ovl = 1'($urandom);
      end
      step(($urandom % 10) < 8, 1'($urandom), ($urandom % 100) < 2, w);
    end

    // Asynchronous reset while a match pulse is showing.
    load_cfg(8'h05, 4'd4, 1'b1, 1'b0);
    stream(8'b0000_0101, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    stream(8'b0000_0101, 4);
    repeat (3) step(1'b0, 1'b0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
